wb_unit: RTL and testbench

// - Writeback stage of the 5-stage RV32I pipeline; write-side counterpart of the decode/regfile-read stage.
// - Holds one MEM/WB instruction. Waits for the data-memory load response, then sign/zero-extends it.
// - Selects the writeback value and drives the regfile write port (we_reg/wr/wd).
// - Also exports the value for ID/EX forwarding and a load-pending hazard flag.

---
 rtl/wb_unit_if.sv | 28 ++
 rtl/wb_unit.sv | 150 +++++++++++++++
 tb/tb_wb_unit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_unit_if.sv
// MEM -> WB instruction handshake bundle.
// master = MEM stage (producer), slave = writeback stage (consumer).
interface wb_unit_if #(
    parameter int XLEN     = 32,
    parameter int RF_ABITS = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [XLEN-1:0]     in_pc;
    logic                in_we;
    logic [RF_ABITS-1:0] in_wr;
    logic [1:0]          in_wb_sel;
    logic [2:0]          in_funct3;
    logic [XLEN-1:0]     in_alu_res;
    logic [XLEN-1:0]     in_imm;

    modport master (
        output in_valid, in_pc, in_we, in_wr,
        output in_wb_sel, in_funct3, in_alu_res, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_we, in_wr,
        input  in_wb_sel, in_funct3, in_alu_res, in_imm,
        output in_ready
    );
endinterface

// File: rtl/wb_unit.sv
// RV32I writeback stage: holds one MEM/WB op, extends load data, drives regfile write.
// Optional WB_TRACE_EN adds debug_wb_* commit trace outputs.
module wb_unit #(
    parameter int XLEN     = 32,
    parameter int RF_ABITS = 5
) (
    input  logic                clk,
    input  logic                rst,
    wb_unit_if.slave            mem,
    input  logic                dm_rvalid,
    input  logic [XLEN-1:0]     dm_rdata,
    output logic                we_reg,
    output logic [RF_ABITS-1:0] wr,
    output logic [XLEN-1:0]     wd,
    output logic                fwd_valid,
    output logic [RF_ABITS-1:0] fwd_wr,
    output logic [XLEN-1:0]     fwd_wd,
`ifdef WB_TRACE_EN
    output logic [XLEN-1:0]     debug_wb_pc,
    output logic [3:0]          debug_wb_rf_we,
    output logic [RF_ABITS-1:0] debug_wb_rf_wnum,
    output logic [XLEN-1:0]     debug_wb_rf_wdata,
`endif
    output logic                ld_pending
);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        WAIT_LD = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic                we_q, we_d;
    logic [RF_ABITS-1:0] wr_q, wr_d;
    logic [2:0]          f3_q, f3_d;
    logic [1:0]          off_q, off_d;
    logic [XLEN-1:0]     res_q, res_d;

    logic                xfer;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [XLEN-1:0]     ld_ext;
    logic                wr_nz;

    assign wr_nz = (wr_q != '0);

    always_comb begin
        ld_byte = 8'h00;
        unique case (off_q)
            2'd0: ld_byte = dm_rdata[7:0];
            2'd1: ld_byte = dm_rdata[15:8];
            2'd2: ld_byte = dm_rdata[23:16];
            2'd3: ld_byte = dm_rdata[31:24];
            default: ld_byte = 8'h00;
        endcase
        ld_half = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    end

    // Unknown funct3 falls back to the raw word, same as LW.
    always_comb begin
        ld_ext = dm_rdata;
        case (f3_q)
            3'b000: ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001: ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100: ld_ext = {24'h0, ld_byte};
            3'b101: ld_ext = {16'h0, ld_half};
            default: ld_ext = dm_rdata;
        endcase
    end

    assign mem.in_ready = (state_q != WAIT_LD);
    assign xfer         = mem.in_valid & mem.in_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        we_d    = we_q;
        wr_d    = wr_q;
        f3_d    = f3_q;
        off_d   = off_q;
        res_d   = res_q;
        unique case (state_q)
            EMPTY, FULL: begin
                if (xfer) begin
                    pc_d  = mem.in_pc;
                    we_d  = mem.in_we;
                    wr_d  = mem.in_wr;
                    f3_d  = mem.in_funct3;
                    off_d = mem.in_alu_res[1:0];
                    unique case (mem.in_wb_sel)
                        2'd0: res_d = mem.in_alu_res;
                        2'd1: res_d = mem.in_alu_res;
                        2'd2: res_d = mem.in_pc + 32'd4;
                        2'd3: res_d = mem.in_imm;
                        default: res_d = mem.in_alu_res;
                    endcase
                    state_d = (mem.in_wb_sel == 2'd1) ? WAIT_LD : FULL;
                end else begin
                    state_d = EMPTY;
                end
            end
            WAIT_LD: begin
                if (dm_rvalid) begin
                    res_d   = ld_ext;
                    state_d = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            pc_q    <= '0;
            we_q    <= 1'b0;
            wr_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            we_q    <= we_d;
            wr_q    <= wr_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            res_q   <= res_d;
        end
    end

    // While a load waits, wr carries rd so ID can compare for the stall.
    assign we_reg     = (state_q == FULL) & we_q & wr_nz;
    assign wr         = (state_q != EMPTY) ? wr_q : '0;
    assign wd         = (state_q == FULL) ? res_q : '0;
    assign fwd_valid  = we_reg;
    assign fwd_wr     = wr;
    assign fwd_wd     = wd;
    assign ld_pending = (state_q == WAIT_LD) & we_q & wr_nz;

`ifdef WB_TRACE_EN
    assign debug_wb_pc       = (state_q == FULL) ? pc_q : '0;
    assign debug_wb_rf_we    = {4{we_reg}};
    assign debug_wb_rf_wnum  = (state_q == FULL) ? wr_q : '0;
    assign debug_wb_rf_wdata = wd;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Directed table-driven bench for wb_unit plus multi-cycle corner sequences.
module tb_wb_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dm_rvalid = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        we_reg, fwd_valid, ld_pending;
    logic [4:0]  wr, fwd_wr;
    logic [31:0] wd, fwd_wd;
`ifdef WB_TRACE_EN
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
`endif

    int checks = 0;
    int failures = 0;

    wb_unit_if bus ();

    wb_unit dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (bus),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .we_reg    (we_reg),
        .wr        (wr),
        .wd        (wd),
        .fwd_valid (fwd_valid),
        .fwd_wr    (fwd_wr),
        .fwd_wd    (fwd_wd),
`ifdef WB_TRACE_EN
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_we    (debug_wb_rf_we),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata),
`endif
        .ld_pending(ld_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] imm;
        logic [31:0] rdata;
        logic        we;
        logic [4:0]  rd;
        int          dly;
        logic        exp_we;
        logic [31:0] exp_wd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.in_valid   = 1'b0;
        bus.in_pc      = '0;
        bus.in_we      = 1'b0;
        bus.in_wr      = '0;
        bus.in_wb_sel  = '0;
        bus.in_funct3  = '0;
        bus.in_alu_res = '0;
        bus.in_imm     = '0;
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid   = 1'b1;
        bus.in_pc      = v.pc;
        bus.in_we      = v.we;
        bus.in_wr      = v.rd;
        bus.in_wb_sel  = v.sel;
        bus.in_funct3  = v.f3;
        bus.in_alu_res = v.alu;
        bus.in_imm     = v.imm;
    endtask

    task automatic chk_commit(input string n, input vec_t v);
        chk({n, ".we_reg"}, 32'(we_reg), 32'(v.exp_we));
        chk({n, ".wr"}, 32'(wr), 32'(v.rd));
        chk({n, ".wd"}, wd, v.exp_wd);
        chk({n, ".fwd_valid"}, 32'(fwd_valid), 32'(v.exp_we));
        chk({n, ".fwd_wd"}, fwd_wd, v.exp_wd);
        chk({n, ".in_ready"}, 32'(bus.in_ready), 32'd1);
`ifdef WB_TRACE_EN
        chk({n, ".trace_pc"}, debug_wb_pc, v.pc);
        chk({n, ".trace_we"}, 32'(debug_wb_rf_we), {28'h0, {4{v.exp_we}}});
`endif
    endtask

    task automatic chk_idle(input string n);
        chk({n, ".we_reg"}, 32'(we_reg), 32'd0);
        chk({n, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({n, ".ld_pending"}, 32'(ld_pending), 32'd0);
        chk({n, ".wd"}, wd, 32'd0);
`ifdef WB_TRACE_EN
        chk({n, ".trace_pc"}, debug_wb_pc, 32'd0);
        chk({n, ".trace_wdata"}, debug_wb_rf_wdata, 32'd0);
        chk({n, ".trace_we"}, 32'(debug_wb_rf_we), 32'd0);
`endif
    endtask

    function automatic vec_t mk(input logic [1:0] sel, input logic [2:0] f3,
                                input logic [31:0] pc, input logic [31:0] alu,
                                input logic [31:0] imm, input logic [31:0] rdata,
                                input logic we, input logic [4:0] rd,
                                input int dly, input logic exp_we,
                                input logic [31:0] exp_wd);
        vec_t v;
        v.sel = sel; v.f3 = f3; v.pc = pc; v.alu = alu; v.imm = imm;
        v.rdata = rdata; v.we = we; v.rd = rd; v.dly = dly;
        v.exp_we = exp_we; v.exp_wd = exp_wd;
        return v;
    endfunction

    vec_t vt[12];
    vec_t b;

    initial begin
        // sel f3 pc alu imm rdata we rd dly exp_we exp_wd
        vt[0]  = mk(2'd0, 3'b000, 32'h100, 32'h1234, 0, 0, 1, 5, 0, 1, 32'h1234);
        vt[1]  = mk(2'd1, 3'b000, 32'h104, 32'h2002, 0, 32'h0080FF00, 1, 6, 3, 1, 32'hFFFFFF80);
        vt[2]  = mk(2'd1, 3'b100, 32'h108, 32'h2002, 0, 32'h0080FF00, 1, 6, 3, 1, 32'h00000080);
        vt[3]  = mk(2'd1, 3'b101, 32'h10C, 32'h2002, 0, 32'h0080FF00, 1, 6, 1, 1, 32'h00000080);
        vt[4]  = mk(2'd1, 3'b001, 32'h110, 32'h2001, 0, 32'h12348001, 1, 7, 0, 1, 32'hFFFF8001);
        vt[5]  = mk(2'd1, 3'b010, 32'h114, 32'h2000, 0, 32'hDEADBEEF, 1, 8, 2, 1, 32'hDEADBEEF);
        vt[6]  = mk(2'd2, 3'b000, 32'hFFFFFFFC, 32'h55, 0, 0, 1, 1, 0, 1, 32'h00000000);
        vt[7]  = mk(2'd0, 3'b000, 32'h118, 32'h77, 0, 0, 1, 0, 0, 0, 32'h77);
        vt[8]  = mk(2'd3, 3'b000, 32'h11C, 32'h1, 32'hABCDE000, 0, 1, 9, 0, 1, 32'hABCDE000);
        vt[9]  = mk(2'd0, 3'b000, 32'h120, 32'h99, 0, 0, 0, 10, 0, 0, 32'h99);
        vt[10] = mk(2'd1, 3'b011, 32'h124, 32'h2003, 0, 32'hCAFEF00D, 1, 11, 1, 1, 32'hCAFEF00D);
        vt[11] = mk(2'd1, 3'b000, 32'h128, 32'h2003, 0, 32'h7F000000, 0, 12, 1, 0, 32'h0000007F);

        idle_bus();
        repeat (3) @(negedge clk);
        chk_idle("reset_hold");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("after_reset");

        for (int i = 0; i < 12; i++) begin
            string n;
            n = $sformatf("vec%0d", i);
            drive(vt[i]);
            @(negedge clk);
            idle_bus();
            if (vt[i].sel == 2'd1) begin
                for (int c = 0; c < vt[i].dly; c++) begin
                    chk({n, ".stall_ready"}, 32'(bus.in_ready), 32'd0);
                    chk({n, ".ld_pending"}, 32'(ld_pending),
                        32'(vt[i].we && vt[i].rd != 0));
                    chk({n, ".fwd_wr"}, 32'(fwd_wr), 32'(vt[i].rd));
                    chk({n, ".stall_we"}, 32'(we_reg), 32'd0);
                    @(negedge clk);
                end
                chk({n, ".pre_rvalid_ready"}, 32'(bus.in_ready), 32'd0);
                dm_rvalid = 1'b1;
                dm_rdata  = vt[i].rdata;
                @(negedge clk);
                dm_rvalid = 1'b0;
                dm_rdata  = 32'hA5A5A5A5;
            end
            chk_commit(n, vt[i]);
            @(negedge clk);
            chk_idle({n, ".after"});
        end

        // Back-to-back ALU ops: FULL accepts while committing.
        for (int k = 0; k < 3; k++) begin
            b = mk(2'd0, 3'b000, 32'h200 + 32'(4 * k), 32'h300 + 32'(k), 0, 0,
                   1, 5'(3 + k), 0, 1, 32'h300 + 32'(k));
            drive(b);
            if (k > 0) chk($sformatf("b2b%0d.ready", k), 32'(bus.in_ready), 32'd1);
            @(negedge clk);
            chk($sformatf("b2b%0d.we", k), 32'(we_reg), 32'd1);
            chk($sformatf("b2b%0d.wr", k), 32'(wr), 32'(3 + k));
            chk($sformatf("b2b%0d.wd", k), wd, 32'h300 + 32'(k));
        end
        idle_bus();
        @(negedge clk);
        chk_idle("b2b.after");

        // dm_rvalid while EMPTY is ignored.
        dm_rvalid = 1'b1;
        dm_rdata  = 32'h11111111;
        @(negedge clk);
        dm_rvalid = 1'b0;
        chk_idle("rvalid_empty");

        // dm_rvalid on the transfer cycle must not complete the load.
        b = mk(2'd1, 3'b010, 32'h300, 32'h4000, 0, 32'h0BADF00D, 1, 13, 0, 1, 32'h0BADF00D);
        drive(b);
        dm_rvalid = 1'b1;
        dm_rdata  = 32'hFFFFFFFF;
        @(negedge clk);
        idle_bus();
        dm_rvalid = 1'b0;
        chk("xfer_rvalid.ld_pending", 32'(ld_pending), 32'd1);
        chk("xfer_rvalid.ready", 32'(bus.in_ready), 32'd0);
        chk("xfer_rvalid.we", 32'(we_reg), 32'd0);
        dm_rvalid = 1'b1;
        dm_rdata  = b.rdata;
        @(negedge clk);
        dm_rvalid = 1'b0;
        chk_commit("xfer_rvalid", b);
        @(negedge clk);

        // Reset mid-load drops the pending load.
        b = mk(2'd1, 3'b010, 32'h400, 32'h5000, 0, 32'h12345678, 1, 14, 0, 1, 0);
        drive(b);
        @(negedge clk);
        idle_bus();
        chk("rst_load.ld_pending", 32'(ld_pending), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("rst_load.in_reset");
        rst = 1'b0;
        @(negedge clk);
        dm_rvalid = 1'b1;
        dm_rdata  = 32'h12345678;
        @(negedge clk);
        dm_rvalid = 1'b0;
        chk_idle("rst_load.rvalid");
        chk("rst_load.wr", 32'(wr), 32'd0);
        @(negedge clk);
        chk_idle("rst_load.after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
